lsu_mem_stage: RTL and testbench
================================

Name: lsu_mem_stage

Overview:
- Load/store unit for the MEM stage of the 5-stage RV32I pipeline.
- Consumes memory operations from EX/MEM and issues word-aligned requests to a byte-lane data memory over a valid/ready handshake.
- Extracts and extends load data and returns it toward MEM/WB.
- Holds `busy` to stall upstream while an access is outstanding.
- Supports LB/LH/LW/LBU/LHU/SB/SH/SW, misalignment faults and a response timeout.

Parameters:
TIMEOUT_CYCLES, 256, maximum WAIT-state cycles before `bus_error`; 0 disables the timeout
CNT_W, 9, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clock  input  1  system clock, all state on posedge
reset  input  1  asynchronous, active-high; one clock; forces IDLE and clears all registered outputs
ex_valid  input  1  a memory operation is presented this cycle
ex_mem_read  input  1  operation is a load
ex_mem_write  input  1  operation is a store
ex_funct3  input  3  RV32I funct3 of the load/store
ex_addr  input  32  effective byte address
ex_write_data  input  32  store data (rs2)
ex_rd_addr  input  5  load destination register
busy  output  1  combinational; high whenever state != IDLE
dmem_req_valid  output  1  request valid
dmem_req_ready  input  1  memory accepts the request
dmem_req_addr  output  32  `{addr[31:2], 2'b00}`
dmem_req_we  output  1  1 = store
dmem_req_wstrb  output  4  byte enables
dmem_req_wdata  output  32  lane-replicated store data
dmem_resp_valid  input  1  read data valid
dmem_resp_rdata  input  32  aligned read word
wb_valid  output  1  one-cycle pulse: load data ready
wb_rd_addr  output  5  load destination
wb_data  output  32  extended load result
misaligned_fault  output  1  one-cycle pulse
bus_error  output  1  one-cycle pulse on timeout
fault_addr  output  32  address of the last faulting access; holds until the next fault

Behaviour:
Reset:
- All outputs are 0, state = IDLE, counter = 0.
- Reset asserted mid-operation abandons the access.
- `dmem_resp_valid` is ignored in IDLE and REQ.

States:
- IDLE
  - Accept when `ex_valid && (ex_mem_read ^ ex_mem_write)`.
  - `ex_valid` with both or neither of read/write set is ignored.
- Legality check on accept:
  - Load funct3 000/100: always legal. 001/101: requires `addr[0]=0`. 010: requires `addr[1:0]=0`. 011/110/111: illegal.
  - Store funct3 000: always legal. 001: requires `addr[0]=0`. 010: requires `addr[1:0]=0`. Other values: illegal.
  - Illegal → `misaligned_fault`=1 in the next cycle, `fault_addr`=ex_addr, no memory request, remain IDLE.
  - Legal → latch the operation, go to REQ.
- REQ
  - `dmem_req_*` are driven from latched registers and held stable while `dmem_req_valid`=1.
  - Handshake when `dmem_req_valid && dmem_req_ready`.
  - Store: on handshake go to IDLE; no response is expected.
  - Load: on handshake go to WAIT and clear the counter.
- WAIT
  - On `dmem_resp_valid`: next cycle `wb_valid`=1, `wb_rd_addr`=latched rd, `wb_data`=extracted value; go to IDLE.
  - Otherwise increment the counter.
  - If TIMEOUT_CYCLES≠0 and counter reaches TIMEOUT_CYCLES-1 with no response: `bus_error`=1 next cycle, `fault_addr`=addr, go to IDLE, no `wb_valid`.
  - A late response arriving after timeout is ignored.

Store lane rules, with a = addr[1:0]:
- SB: `wstrb = 4'b0001 << a`; `wdata = {4{data[7:0]}}`.
- SH: `wstrb = a[1] ? 4'b1100 : 4'b0011`; `wdata = {2{data[15:0]}}`.
- SW: `wstrb = 4'b1111`; `wdata = data`.

Load extraction:
- Byte = `rdata[8a+7:8a]`.
- Half = `rdata[16a[1]+15:16a[1]]`.
- LB/LH sign-extend to 32 bits; LBU/LHU zero-extend; LW passes through.

Timing and boundaries:
- Latency with `dmem_req_ready`=1 and a response one cycle after handshake:
  - Accept at cycle 0, REQ at 1, WAIT at 2, `resp_valid` at 2, `wb_valid` at 3.
  - A store occupies IDLE→REQ→IDLE, so `busy` is high for 1 cycle.
- Upstream holds `ex_*` and does not re-present the operation while `busy`=1.
- The block accepts the next op in the cycle it returns to IDLE.
- `wb_valid` pulses even for rd=0; writeback logic discards it.
- `wb_data` and `wb_rd_addr` hold their value after the pulse.
- Address arithmetic wraps at 2^32; no bounds checking is performed.

Test Plan:
1. SW addr 0x100 data 0xDEADBEEF, then LW 0x100 (memory model returns the stored word) → wstrb 1111; `wb_valid` 1 cycle, `wb_data`=0xDEADBEEF, `busy` high 1 cycle for the store and 2 cycles for the load (zero-wait).
2. Word 0x80FF7F01 at 0x200: LB 0x203→0xFFFFFF80, LBU 0x203→0x00000080, LB 0x200→0x00000001, LH 0x202→0xFFFF80FF, LHU 0x202→0x000080FF.
3. SB 0x305 data 0x000000AB → req_addr 0x304, wstrb 0010, wdata 0xABABABAB; SH 0x306 data 0x1234 → wstrb 1100, wdata 0x12341234.
4. LW 0x101, SH 0x103, funct3 011 → `misaligned_fault` pulse, `fault_addr`=ex_addr, zero `dmem_req_valid` cycles, `busy` stays 0.
5. Hold `dmem_req_ready`=0 for 5 cycles then 1 → request fields stable all 6 cycles; exactly one handshake. With TIMEOUT_CYCLES=4 and no response → `bus_error` pulse, no `wb_valid`, returns to IDLE.
6. Assert reset while in WAIT, then deliver `resp_valid` → all outputs 0, state IDLE, no `wb_valid`; the next LW completes normally.

Source files
------------

// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit: legality check on accept, a single outstanding
// word-aligned data-memory access, and load extraction toward writeback.
module lsu_mem_stage #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 9
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_write_data,
  input  logic [4:0]  ex_rd_addr,
  output logic        busy,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic [31:0] dmem_req_addr,
  output logic        dmem_req_we,
  output logic [3:0]  dmem_req_wstrb,
  output logic [31:0] dmem_req_wdata,
  input  logic        dmem_resp_valid,
  input  logic [31:0] dmem_resp_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd_addr,
  output logic [31:0] wb_data,
  output logic        misaligned_fault,
  output logic        bus_error,
  output logic [31:0] fault_addr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  localparam bit               LP_TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] LP_LAST  =
    (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_addr;
  logic             r_we;
  logic [2:0]       r_funct3;
  logic [4:0]       r_rd;
  logic [3:0]       r_wstrb;
  logic [31:0]      r_wdata;
  logic             r_wb_valid;
  logic [4:0]       r_wb_rd;
  logic [31:0]      r_wb_data;
  logic             r_misaligned;
  logic             r_bus_error;
  logic [31:0]      r_fault_addr;

  logic             w_accept;
  logic             w_legal;
  logic [3:0]       w_st_wstrb;
  logic [31:0]      w_st_wdata;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [31:0]      w_load_data;
  logic             w_timeout;

  assign w_accept  = ex_valid && (ex_mem_read ^ ex_mem_write);
  assign w_timeout = LP_TO_EN && (r_count == LP_LAST);

  // Loads have two extra legal encodings (LBU/LHU); stores only SB/SH/SW.
  always_comb begin
    w_legal = 1'b0;
    if (ex_mem_read) begin
      case (ex_funct3)
        3'b000, 3'b100: w_legal = 1'b1;
        3'b001, 3'b101: w_legal = ~ex_addr[0];
        3'b010:         w_legal = (ex_addr[1:0] == 2'b00);
        default:        w_legal = 1'b0;
      endcase
    end else begin
      case (ex_funct3)
        3'b000:  w_legal = 1'b1;
        3'b001:  w_legal = ~ex_addr[0];
        3'b010:  w_legal = (ex_addr[1:0] == 2'b00);
        default: w_legal = 1'b0;
      endcase
    end
  end

  always_comb begin
    w_st_wstrb = 4'b0000;
    w_st_wdata = 32'h0;
    if (ex_mem_write) begin
      case (ex_funct3[1:0])
        2'b00: begin
          w_st_wstrb = 4'b0001 << ex_addr[1:0];
          w_st_wdata = {4{ex_write_data[7:0]}};
        end
        2'b01: begin
          w_st_wstrb = ex_addr[1] ? 4'b1100 : 4'b0011;
          w_st_wdata = {2{ex_write_data[15:0]}};
        end
        default: begin
          w_st_wstrb = 4'b1111;
          w_st_wdata = ex_write_data;
        end
      endcase
    end
  end

  always_comb begin
    case (r_addr[1:0])
      2'b00:   w_byte = dmem_resp_rdata[7:0];
      2'b01:   w_byte = dmem_resp_rdata[15:8];
      2'b10:   w_byte = dmem_resp_rdata[23:16];
      default: w_byte = dmem_resp_rdata[31:24];
    endcase
    w_half = r_addr[1] ? dmem_resp_rdata[31:16] : dmem_resp_rdata[15:0];
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load_data = {24'h0, w_byte};
      3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b101:  w_load_data = {16'h0, w_half};
      default: w_load_data = dmem_resp_rdata;
    endcase
  end

  // Response wins over timeout when both land on the last WAIT cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_count      <= '0;
      r_addr       <= 32'h0;
      r_we         <= 1'b0;
      r_funct3     <= 3'b000;
      r_rd         <= 5'd0;
      r_wstrb      <= 4'b0000;
      r_wdata      <= 32'h0;
      r_wb_valid   <= 1'b0;
      r_wb_rd      <= 5'd0;
      r_wb_data    <= 32'h0;
      r_misaligned <= 1'b0;
      r_bus_error  <= 1'b0;
      r_fault_addr <= 32'h0;
    end else begin
      r_wb_valid   <= 1'b0;
      r_misaligned <= 1'b0;
      r_bus_error  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (!w_legal) begin
              r_misaligned <= 1'b1;
              r_fault_addr <= ex_addr;
            end else begin
              r_addr   <= ex_addr;
              r_we     <= ex_mem_write;
              r_funct3 <= ex_funct3;
              r_rd     <= ex_rd_addr;
              r_wstrb  <= w_st_wstrb;
              r_wdata  <= w_st_wdata;
              r_state  <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (dmem_req_ready) begin
            r_count <= '0;
            r_state <= r_we ? S_IDLE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (dmem_resp_valid) begin
            r_wb_valid <= 1'b1;
            r_wb_rd    <= r_rd;
            r_wb_data  <= w_load_data;
            r_state    <= S_IDLE;
          end else if (w_timeout) begin
            r_bus_error  <= 1'b1;
            r_fault_addr <= r_addr;
            r_state      <= S_IDLE;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy             = (r_state != S_IDLE);
  assign dmem_req_valid   = (r_state == S_REQ);
  assign dmem_req_addr    = {r_addr[31:2], 2'b00};
  assign dmem_req_we      = r_we;
  assign dmem_req_wstrb   = r_wstrb;
  assign dmem_req_wdata   = r_wdata;
  assign wb_valid         = r_wb_valid;
  assign wb_rd_addr       = r_wb_rd;
  assign wb_data          = r_wb_data;
  assign misaligned_fault = r_misaligned;
  assign bus_error        = r_bus_error;
  assign fault_addr       = r_fault_addr;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage: byte-addressed memory model plus
// per-scenario tasks comparing the DUT against size/offset arithmetic.
module tb_lsu_mem_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        ex_valid, ex_mem_read, ex_mem_write;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_write_data;
  logic [4:0]  ex_rd_addr;
  logic        busy, dmem_req_valid, dmem_req_ready, dmem_req_we;
  logic [31:0] dmem_req_addr, dmem_req_wdata;
  logic [3:0]  dmem_req_wstrb;
  logic        dmem_resp_valid;
  logic [31:0] dmem_resp_rdata;
  logic        wb_valid, misaligned_fault, bus_error;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_data, fault_addr;

  always #5 clock = ~clock;

  lsu_mem_stage #(.TIMEOUT_CYCLES(4), .CNT_W(9)) dut (
    .clock(clock), .reset(reset),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_write_data(ex_write_data),
    .ex_rd_addr(ex_rd_addr), .busy(busy),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_req_addr(dmem_req_addr), .dmem_req_we(dmem_req_we),
    .dmem_req_wstrb(dmem_req_wstrb), .dmem_req_wdata(dmem_req_wdata),
    .dmem_resp_valid(dmem_resp_valid), .dmem_resp_rdata(dmem_resp_rdata),
    .wb_valid(wb_valid), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
    .misaligned_fault(misaligned_fault), .bus_error(bus_error),
    .fault_addr(fault_addr)
  );

  int compared   = 0;
  int mismatched = 0;

  bit [7:0] mem [bit [31:0]];

  int          obsBusy, obsReqValid, obsHs, obsWb, obsMis, obsBus;
  bit          obsStable;
  logic [31:0] obsReqAddr, obsWdata, obsWbData, obsFaultAddr;
  logic [3:0]  obsWstrb;
  logic        obsWe;
  logic [4:0]  obsWbRd;

  // Reference model: accesses described by size and byte address only.
  function automatic int opSize(input bit isLoad, input logic [2:0] f3);
    if (isLoad) begin
      case (f3)
        3'd0, 3'd4: return 1;
        3'd1, 3'd5: return 2;
        3'd2:       return 4;
        default:    return 0;
      endcase
    end
    case (f3)
      3'd0:    return 1;
      3'd1:    return 2;
      3'd2:    return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit isLegal(input bit isLoad, input logic [2:0] f3, input logic [31:0] a);
    int s = opSize(isLoad, f3);
    return (s != 0) && ((a % s) == 0);
  endfunction

  function automatic logic [7:0] byteAt(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 8'h00;
  endfunction

  function automatic logic [31:0] memWord(input logic [31:0] a);
    logic [31:0] b = a & 32'hFFFF_FFFC;
    return {byteAt(b + 3), byteAt(b + 2), byteAt(b + 1), byteAt(b)};
  endfunction

  function automatic logic [31:0] expLoad(input logic [2:0] f3, input logic [31:0] a);
    int s = opSize(1'b1, f3);
    logic [63:0] v = '0;
    for (int i = 0; i < s; i++) v = v | (64'(byteAt(a + i)) << (8 * i));
    if (!f3[2] && s < 4 && v[8*s-1]) v = v | ~((64'd1 << (8 * s)) - 64'd1);
    return v[31:0];
  endfunction

  function automatic logic [3:0] expWstrb(input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] m = '0;
    int s = opSize(1'b0, f3);
    for (int i = 0; i < s; i++) m[int'(a[1:0]) + i] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] expWdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w = '0;
    int s = opSize(1'b0, f3);
    for (int lane = 0; lane < 4; lane++) w[8*lane +: 8] = d[8*(lane % s) +: 8];
    return w;
  endfunction

  task automatic memStore(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int s = opSize(1'b0, f3);
    for (int i = 0; i < s; i++) mem[a + i] = d[8*i +: 8];
  endtask

  // Drives one op and plays the memory side; records what the DUT did.
  task automatic runOp(input bit isLoad, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input logic [4:0] rd,
                       input int readyDelay, input int respDelay);
    int idle = 0, cyc = 0, waitIdx = 0, reqWait = 0;
    bit inWait = 0, haveFirst = 0;
    obsBusy = 0; obsReqValid = 0; obsHs = 0; obsWb = 0; obsMis = 0; obsBus = 0;
    obsStable = 1; obsReqAddr = 'x; obsWdata = 'x; obsWstrb = 'x; obsWe = 'x;
    obsWbData = 'x; obsWbRd = 'x;
    @(negedge clock);
    ex_valid = 1; ex_mem_read = isLoad; ex_mem_write = !isLoad; ex_funct3 = f3;
    ex_addr = a; ex_write_data = d; ex_rd_addr = rd;
    @(negedge clock);
    ex_valid = 0;
    while (idle < 4 && cyc < 60) begin
      if (busy) obsBusy++;
      idle = busy ? 0 : idle + 1;
      if (wb_valid) begin obsWb++; obsWbData = wb_data; obsWbRd = wb_rd_addr; end
      if (misaligned_fault) obsMis++;
      if (bus_error) obsBus++;
      dmem_resp_valid = 0;
      dmem_resp_rdata = $urandom;
      if (inWait) begin
        if (waitIdx == respDelay) begin
          dmem_resp_valid = 1; dmem_resp_rdata = memWord(a); inWait = 0;
        end
        waitIdx++;
      end
      dmem_req_ready = 0;
      if (dmem_req_valid) begin
        obsReqValid++;
        if (!haveFirst) begin
          haveFirst = 1; obsReqAddr = dmem_req_addr; obsWe = dmem_req_we;
          obsWstrb = dmem_req_wstrb; obsWdata = dmem_req_wdata;
        end else if ({dmem_req_addr, dmem_req_we, dmem_req_wstrb, dmem_req_wdata} !==
                     {obsReqAddr, obsWe, obsWstrb, obsWdata}) obsStable = 0;
        if (reqWait >= readyDelay) begin
          dmem_req_ready = 1; obsHs++;
          if (isLoad) begin inWait = 1; waitIdx = 0; end
        end
        reqWait++;
      end
      cyc++;
      @(negedge clock);
    end
    dmem_resp_valid = 0; dmem_req_ready = 0;
    obsFaultAddr = fault_addr;
    compared++;
    if (cyc >= 60) begin
      mismatched++;
      $display("[TB] FAIL op_bound: busy still %b after %0d cycles, required idle", busy, cyc);
    end
  endtask

  task automatic test_reset;
    reset = 1;
    ex_valid = 0; ex_mem_read = 0; ex_mem_write = 0; ex_funct3 = 0; ex_addr = 0;
    ex_write_data = 0; ex_rd_addr = 0; dmem_req_ready = 0; dmem_resp_valid = 0;
    dmem_resp_rdata = 0;
    repeat (2) @(negedge clock);
    compared++;
    if ({busy, dmem_req_valid, dmem_req_we, dmem_req_wstrb, wb_valid, wb_rd_addr,
         misaligned_fault, bus_error} !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_ctrl: got busy=%b vld=%b we=%b strb=%b wb=%b rd=%0d mis=%b berr=%b required all 0",
               busy, dmem_req_valid, dmem_req_we, dmem_req_wstrb, wb_valid, wb_rd_addr,
               misaligned_fault, bus_error);
    end
    compared++;
    if ({dmem_req_addr, dmem_req_wdata, wb_data, fault_addr} !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_data: got addr=%h wdata=%h wb=%h fa=%h required 0",
               dmem_req_addr, dmem_req_wdata, wb_data, fault_addr);
    end
    reset = 0;
    @(negedge clock);
  endtask

  task automatic test_store_load;
    runOp(0, 3'd2, 32'h100, 32'hDEADBEEF, 5'd0, 0, 0);
    memStore(3'd2, 32'h100, 32'hDEADBEEF);
    compared++;
    if ({obsHs, obsWstrb, obsWdata, obsWe} !== {32'd1, 4'b1111, 32'hDEADBEEF, 1'b1}) begin
      mismatched++;
      $display("[TB] FAIL sw_req: got hs=%0d strb=%b wdata=%h we=%b required 1/1111/deadbeef/1",
               obsHs, obsWstrb, obsWdata, obsWe);
    end
    compared++;
    if (obsBusy !== 1) begin
      mismatched++; $display("[TB] FAIL sw_busy: got %0d cycles required 1", obsBusy);
    end
    runOp(1, 3'd2, 32'h100, 32'h0, 5'd5, 0, 0);
    compared++;
    if ({obsWb, obsWbData, obsWbRd} !== {32'd1, 32'hDEADBEEF, 5'd5}) begin
      mismatched++;
      $display("[TB] FAIL lw_wb: got n=%0d data=%h rd=%0d required 1/deadbeef/5",
               obsWb, obsWbData, obsWbRd);
    end
    compared++;
    if (obsBusy !== 2) begin
      mismatched++; $display("[TB] FAIL lw_busy: got %0d cycles required 2", obsBusy);
    end
    compared++;
    if ({wb_valid, wb_data, wb_rd_addr} !== {1'b0, 32'hDEADBEEF, 5'd5}) begin
      mismatched++;
      $display("[TB] FAIL wb_hold: got v=%b data=%h rd=%0d required 0/deadbeef/5",
               wb_valid, wb_data, wb_rd_addr);
    end
  endtask

  task automatic test_load_extend;
    logic [2:0]  f3s [5] = '{3'd0, 3'd4, 3'd0, 3'd1, 3'd5};
    logic [31:0] ads [5] = '{32'h203, 32'h203, 32'h200, 32'h202, 32'h202};
    logic [31:0] exs [5] = '{32'hFFFFFF80, 32'h00000080, 32'h00000001, 32'hFFFF80FF, 32'h000080FF};
    memStore(3'd2, 32'h200, 32'h80FF7F01);
    for (int i = 0; i < 5; i++) begin
      runOp(1, f3s[i], ads[i], 32'h0, 5'(i), 0, i % 3);
      compared++;
      if ({obsWb, obsWbData, obsWbRd} !== {32'd1, exs[i], 5'(i)}) begin
        mismatched++;
        $display("[TB] FAIL load_ext%0d: got n=%0d data=%h rd=%0d required 1/%h/%0d",
                 i, obsWb, obsWbData, obsWbRd, exs[i], i);
      end
    end
  endtask

  task automatic test_store_lanes;
    runOp(0, 3'd0, 32'h305, 32'h000000AB, 5'd0, 0, 0);
    memStore(3'd0, 32'h305, 32'h000000AB);
    compared++;
    if ({obsReqAddr, obsWstrb, obsWdata} !== {32'h304, 4'b0010, 32'hABABABAB}) begin
      mismatched++;
      $display("[TB] FAIL sb_lanes: got addr=%h strb=%b wdata=%h required 304/0010/abababab",
               obsReqAddr, obsWstrb, obsWdata);
    end
    runOp(0, 3'd1, 32'h306, 32'h00001234, 5'd0, 0, 0);
    memStore(3'd1, 32'h306, 32'h00001234);
    compared++;
    if ({obsReqAddr, obsWstrb, obsWdata} !== {32'h304, 4'b1100, 32'h12341234}) begin
      mismatched++;
      $display("[TB] FAIL sh_lanes: got addr=%h strb=%b wdata=%h required 304/1100/12341234",
               obsReqAddr, obsWstrb, obsWdata);
    end
  endtask

  task automatic test_misaligned;
    bit          lds [3] = '{1'b1, 1'b0, 1'b1};
    logic [2:0]  f3s [3] = '{3'd2, 3'd1, 3'd3};
    logic [31:0] ads [3] = '{32'h101, 32'h103, 32'h208};
    for (int i = 0; i < 3; i++) begin
      runOp(lds[i], f3s[i], ads[i], 32'h5555AAAA, 5'd3, 0, 0);
      compared++;
      if ({obsMis, obsReqValid, obsBusy, obsWb, obsFaultAddr} !==
          {32'd1, 32'd0, 32'd0, 32'd0, ads[i]}) begin
        mismatched++;
        $display("[TB] FAIL misaligned%0d: got mis=%0d reqv=%0d busy=%0d wb=%0d fa=%h required 1/0/0/0/%h",
                 i, obsMis, obsReqValid, obsBusy, obsWb, obsFaultAddr, ads[i]);
      end
    end
    @(negedge clock);
    ex_valid = 1; ex_mem_read = 1; ex_mem_write = 1; ex_funct3 = 3'd3; ex_addr = 32'h777;
    @(negedge clock);
    ex_valid = 0;
    compared++;
    if ({busy, misaligned_fault, dmem_req_valid} !== 3'b000) begin
      mismatched++;
      $display("[TB] FAIL rw_both_ignored: got busy=%b mis=%b reqv=%b required 000",
               busy, misaligned_fault, dmem_req_valid);
    end
  endtask

  task automatic test_backpressure_timeout;
    runOp(0, 3'd2, 32'h500, 32'hCAFEF00D, 5'd0, 5, 0);
    memStore(3'd2, 32'h500, 32'hCAFEF00D);
    compared++;
    if ({obsReqValid, obsHs, 31'(obsStable), obsBusy} !== {32'd6, 32'd1, 31'd1, 32'd6}) begin
      mismatched++;
      $display("[TB] FAIL backpressure: got reqv=%0d hs=%0d stable=%b busy=%0d required 6/1/1/6",
               obsReqValid, obsHs, obsStable, obsBusy);
    end
    runOp(1, 3'd2, 32'h500, 32'h0, 5'd9, 2, 5);
    compared++;
    if ({obsBus, obsWb, obsFaultAddr, obsBusy} !== {32'd1, 32'd0, 32'h500, 32'd7}) begin
      mismatched++;
      $display("[TB] FAIL timeout: got berr=%0d wb=%0d fa=%h busy=%0d required 1/0/500/7",
               obsBus, obsWb, obsFaultAddr, obsBusy);
    end
  endtask

  task automatic test_reset_in_wait;
    @(negedge clock);
    ex_valid = 1; ex_mem_read = 1; ex_mem_write = 0; ex_funct3 = 3'd2;
    ex_addr = 32'h200; ex_rd_addr = 5'd7;
    @(negedge clock);
    ex_valid = 0; dmem_req_ready = 1;
    @(negedge clock);
    dmem_req_ready = 0; reset = 1;
    @(negedge clock);
    reset = 0; dmem_resp_valid = 1; dmem_resp_rdata = memWord(32'h200);
    @(negedge clock);
    dmem_resp_valid = 0;
    compared++;
    if ({busy, dmem_req_valid, wb_valid, wb_data, wb_rd_addr, fault_addr, misaligned_fault, bus_error} !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_wait: got busy=%b reqv=%b wb=%b data=%h rd=%0d fa=%h required all 0",
               busy, dmem_req_valid, wb_valid, wb_data, wb_rd_addr, fault_addr);
    end
    runOp(1, 3'd2, 32'h200, 32'h0, 5'd7, 0, 1);
    compared++;
    if ({obsWb, obsWbData, obsWbRd} !== {32'd1, 32'h80FF7F01, 5'd7}) begin
      mismatched++;
      $display("[TB] FAIL after_reset_lw: got n=%0d data=%h rd=%0d required 1/80ff7f01/7",
               obsWb, obsWbData, obsWbRd);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clock);
    ex_valid = 1; ex_mem_read = 0; ex_mem_write = 1; ex_funct3 = 3'd2;
    ex_addr = 32'h400; ex_write_data = 32'h0BADC0DE;
    @(negedge clock);
    ex_valid = 0; dmem_req_ready = 1;
    memStore(3'd2, 32'h400, 32'h0BADC0DE);
    @(negedge clock);
    dmem_req_ready = 0;
    ex_valid = 1; ex_mem_read = 1; ex_mem_write = 0; ex_rd_addr = 5'd9;
    @(negedge clock);
    ex_valid = 0;
    compared++;
    if ({busy, dmem_req_valid, dmem_req_we, dmem_req_addr} !== {3'b110, 32'h400}) begin
      mismatched++;
      $display("[TB] FAIL b2b_accept: got busy=%b reqv=%b we=%b addr=%h required 1/1/0/400",
               busy, dmem_req_valid, dmem_req_we, dmem_req_addr);
    end
    dmem_req_ready = 1;
    @(negedge clock);
    dmem_req_ready = 0; dmem_resp_valid = 1; dmem_resp_rdata = memWord(32'h400);
    @(negedge clock);
    dmem_resp_valid = 0;
    compared++;
    if ({wb_valid, wb_data, wb_rd_addr, busy} !== {1'b1, 32'h0BADC0DE, 5'd9, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL b2b_load: got v=%b data=%h rd=%0d busy=%b required 1/0badc0de/9/0",
               wb_valid, wb_data, wb_rd_addr, busy);
    end
  endtask

  task automatic test_random;
    for (int a = 32'h1000; a < 32'h1040; a++) mem[a] = 8'($urandom);
    for (int n = 0; n < 60; n++) begin
      bit          ld = 1'($urandom_range(0, 1));
      logic [2:0]  f3 = 3'($urandom_range(0, 7));
      logic [31:0] a  = 32'h1000 + $urandom_range(0, 63);
      logic [31:0] d  = $urandom;
      logic [4:0]  rd = 5'($urandom);
      int          rdyD = $urandom_range(0, 3);
      int          rspD = $urandom_range(0, 3);
      int          s;
      logic [31:0] expD;
      if ($urandom_range(0, 3) != 0) begin
        if (ld) begin
          case ($urandom_range(0, 4))
            0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
          endcase
        end else f3 = 3'($urandom_range(0, 2));
      end
      s = opSize(ld, f3);
      if (s != 0 && $urandom_range(0, 3) != 0) a = a & ~32'(s - 1);
      expD = ld ? expLoad(f3, a) : 32'h0;
      runOp(ld, f3, a, d, rd, rdyD, rspD);
      if (!isLegal(ld, f3, a)) begin
        compared++;
        if ({obsMis, obsReqValid, obsBusy, obsFaultAddr} !== {32'd1, 32'd0, 32'd0, a}) begin
          mismatched++;
          $display("[TB] FAIL rnd%0d_fault: got mis=%0d reqv=%0d busy=%0d fa=%h required 1/0/0/%h",
                   n, obsMis, obsReqValid, obsBusy, obsFaultAddr, a);
        end
      end else if (ld) begin
        compared++;
        if ({obsWb, obsWbData, obsWbRd, obsReqAddr, obsWe, obsBusy} !==
            {32'd1, expD, rd, a & 32'hFFFF_FFFC, 1'b0, 32'(rdyD + rspD + 2)}) begin
          mismatched++;
          $display("[TB] FAIL rnd%0d_load: got n=%0d data=%h rd=%0d addr=%h we=%b busy=%0d required 1/%h/%0d/%h/0/%0d",
                   n, obsWb, obsWbData, obsWbRd, obsReqAddr, obsWe, obsBusy,
                   expD, rd, a & 32'hFFFF_FFFC, rdyD + rspD + 2);
        end
      end else begin
        compared++;
        if ({obsHs, obsWstrb, obsWdata, obsReqAddr, obsWe, obsBusy, 31'(obsStable)} !==
            {32'd1, expWstrb(f3, a), expWdata(f3, d), a & 32'hFFFF_FFFC, 1'b1, 32'(rdyD + 1), 31'd1}) begin
          mismatched++;
          $display("[TB] FAIL rnd%0d_store: got strb=%b wdata=%h addr=%h busy=%0d required %b/%h/%h/%0d",
                   n, obsWstrb, obsWdata, obsReqAddr, obsBusy,
                   expWstrb(f3, a), expWdata(f3, d), a & 32'hFFFF_FFFC, rdyD + 1);
        end
        memStore(f3, a, d);
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_load_extend();
    test_store_lanes();
    test_misaligned();
    test_backpressure_timeout();
    test_reset_in_wait();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
